// File: rtl/synch_down_counter_pkg.sv
// Shared constants for the loadable synchronous down counter.
package synch_down_counter_pkg;

  // Default count width, matching the 4-bit up counter it sits next to.
  localparam int DEF_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/synch_down_counter_if.sv
// Control/status bundle for synch_down_counter.
// master: the block that programs the counter; slave: the counter itself.
interface synch_down_counter_if
  import synch_down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, en,
    input  Q, tc, busy, done
  );

  modport slave (
    input  load, load_val, en,
    output Q, tc, busy, done
  );

endinterface

// File: rtl/synch_down_counter.sv
// Loadable synchronous down counter / countdown timer.
// Counts a loaded value down to zero under en, pulses tc on arrival at zero
// and reports busy (RUN) / done (DONE) from the registered state.
// Optional feature: define SYNCH_DOWN_CNT_AUTO_RELOAD_EN to make the counter
// free-run, reloading from the last loaded value after reaching zero instead
// of stopping in DONE.
module synch_down_counter
  import synch_down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  synch_down_counter_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  logic             cnt_is_one;
  logic             cnt_is_zero;
  logic             step;

  assign cnt_is_one  = (cnt_q == WIDTH'(1));
  assign cnt_is_zero = (cnt_q == '0);
  // A decrement/reload opportunity: counting state, enabled, no load pending.
  assign step        = !bus.load && bus.en && (state_q == ST_RUN);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: load wins over everything; a zero load parks in IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = (bus.load_val != '0) ? ST_RUN : ST_IDLE;
    end else if (step && cnt_is_one) begin
`ifdef SYNCH_DOWN_CNT_AUTO_RELOAD_EN
      state_d = ST_RUN;
`else
      state_d = ST_DONE;
`endif
    end
  end

  // Count and reload value: load, decrement, and (optionally) wrap to reload.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      cnt_d    = bus.load_val;
      reload_d = bus.load_val;
    end else if (step) begin
      if (cnt_is_one) begin
        cnt_d = '0;
        tc_d  = 1'b1;
      end else if (cnt_is_zero) begin
`ifdef SYNCH_DOWN_CNT_AUTO_RELOAD_EN
        cnt_d = reload_q;
`else
        // Unreachable in one-shot mode; hold rather than underflow.
        cnt_d = cnt_q;
`endif
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // Count and reload registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  // Registered terminal-count pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tc_q <= 1'b0;
    else          tc_q <= tc_d;
  end

  // Outputs: all straight from flops, so status lines are glitch-free.
  always_comb begin
    bus.Q    = cnt_q;
    bus.tc   = tc_q;
    bus.busy = (state_q == ST_RUN);
    bus.done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_synch_down_counter.sv
// Bench for synch_down_counter: directed vectors with literal expectations,
// plus a per-cycle comparison against a behavioural countdown model.
module tb_synch_down_counter;

  localparam int W = 4;
`ifdef SYNCH_DOWN_CNT_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  synch_down_counter_if #(.WIDTH(W)) bus ();

  synch_down_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: remaining count, whether it is counting, whether it
  // has finished, and the pulse for "just reached zero".
  logic [W-1:0] m_q, m_rel;
  logic         m_run, m_done, m_tc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0; m_rel <= '0; m_run <= 1'b0; m_done <= 1'b0; m_tc <= 1'b0;
    end else if (bus.load) begin
      m_q    <= bus.load_val;
      m_rel  <= bus.load_val;
      m_run  <= (bus.load_val != 0);
      m_done <= 1'b0;
      m_tc   <= 1'b0;
    end else if (m_run && bus.en) begin
      if (m_q == 1) begin
        m_q  <= 0;
        m_tc <= 1'b1;
        if (!AUTO) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (m_q == 0) begin
        m_q  <= m_rel;
        m_tc <= 1'b0;
      end else begin
        m_q  <= m_q - 1'b1;
        m_tc <= 1'b0;
      end
    end else begin
      m_tc <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_Q", int'(bus.Q), int'(m_q));
    chk("model_tc", int'(bus.tc), int'(m_tc));
    chk("model_busy", int'(bus.busy), int'(m_run));
    chk("model_done", int'(bus.done), int'(m_done));
  end

  // Apply inputs, take one edge, settle just after it.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic e);
    bus.load     = ld;
    bus.load_val = lv;
    bus.en       = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int q, input int tc,
                         input int busy, input int done);
    chk({name, "_Q"},    int'(bus.Q),    q);
    chk({name, "_tc"},   int'(bus.tc),   tc);
    chk({name, "_busy"}, int'(bus.busy), busy);
    chk({name, "_done"}, int'(bus.done), done);
  endtask

  int tc_seen;

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
    #2 reset_n = 1'b1;
    #1;
    chk_all("reset", 0, 0, 0, 0);

`ifndef SYNCH_DOWN_CNT_AUTO_RELOAD_EN
    // One-shot countdown from 3.
    step(1'b1, 4'd3, 1'b1); chk_all("os_load", 3, 0, 1, 0);
    step(1'b0, 4'd0, 1'b1); chk_all("os_2", 2, 0, 1, 0);
    step(1'b0, 4'd0, 1'b1); chk_all("os_1", 1, 0, 1, 0);
    step(1'b0, 4'd0, 1'b1); chk_all("os_0", 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 1'b1); chk_all("os_hold", 0, 0, 0, 1);
    end
`endif

    // Enable gating.
    step(1'b1, 4'd5, 1'b0); chk("en_load", int'(bus.Q), 5);
    step(1'b0, 4'd0, 1'b1); chk("en_1", int'(bus.Q), 4);
    step(1'b0, 4'd0, 1'b0); chk("en_0", int'(bus.Q), 4);
    step(1'b0, 4'd0, 1'b1); chk("en_1b", int'(bus.Q), 3);
    step(1'b0, 4'd0, 1'b1); chk("en_1c", int'(bus.Q), 2);
    // Load beats enable.
    step(1'b1, 4'd9, 1'b1); chk_all("prio", 9, 0, 1, 0);

    // Zero load parks in IDLE and ignores en.
    step(1'b1, 4'd0, 1'b1); chk_all("zero_load", 0, 0, 0, 0);
    step(1'b0, 4'd0, 1'b1); chk_all("zero_idle", 0, 0, 0, 0);

    // Full-scale load: 15 enabled cycles to tc.
    step(1'b1, 4'd15, 1'b1); chk("max_load", int'(bus.Q), 15);
    tc_seen = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 4'd0, 1'b1);
      tc_seen += int'(bus.tc);
    end
    chk("max_early_tc", tc_seen, 0);
    chk("max_at1", int'(bus.Q), 1);
    step(1'b0, 4'd0, 1'b1); chk("max_tc", int'(bus.tc), 1);
    chk("max_zero", int'(bus.Q), 0);
    step(1'b0, 4'd0, 1'b1);
`ifdef SYNCH_DOWN_CNT_AUTO_RELOAD_EN
    chk("max_reload", int'(bus.Q), 15);
`else
    chk("max_no_underflow", int'(bus.Q), 0);
`endif

    // Reset in the middle of a count.
    step(1'b1, 4'd8, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1);
    chk("mid_pre", int'(bus.Q), 5);
    #2 reset_n = 1'b0;
    #1 chk_all("mid_rst", 0, 0, 0, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step(1'b0, 4'd0, 1'b1); chk_all("mid_after", 0, 0, 0, 0);
    step(1'b0, 4'd0, 1'b1); chk_all("mid_after2", 0, 0, 0, 0);

`ifdef SYNCH_DOWN_CNT_AUTO_RELOAD_EN
    // Free-running reload from 2.
    begin
      int exp_seq [9] = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
      int busy_lo = 0;
      int done_hi = 0;
      tc_seen = 0;
      step(1'b1, 4'd2, 1'b1);
      for (int i = 0; i < 9; i++) begin
        if (i > 0) step(1'b0, 4'd0, 1'b1);
        chk("auto_Q", int'(bus.Q), exp_seq[i]);
        tc_seen += int'(bus.tc);
        busy_lo += int'(!bus.busy);
        done_hi += int'(bus.done);
      end
      chk("auto_tc_count", tc_seen, 3);
      chk("auto_busy", busy_lo, 0);
      chk("auto_done", done_hi, 0);
    end
`endif

    step(1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
